// File: rtl/fryer_cook_ctrl.sv
// Air-fryer cook controller: OFF/IDLE/RUN/PAUSE/DONE FSM, BCD mm:ss countdown, heat modes, beeps.
// Define FRYER_PREHEAT_EN to insert a PREHEAT phase between IDLE and RUN.
module fryer_cook_ctrl #(
  parameter int unsigned MODE_NUM   = 3,
  parameter int unsigned TICK_DIV   = 1000,
  parameter int unsigned BEEP_ON    = 250,
  parameter int unsigned BEEP_OFF   = 250,
  parameter int unsigned BEEP_COUNT = 3,
  parameter int unsigned PREHEAT_S  = 5
) (
  input  logic       clk_1Khz,
  input  logic       rst,
  input  logic       sw_power,
  input  logic       btn_start,
  input  logic       btn_reset,
  input  logic       btn_pause,
  input  logic       btn_mode,
  input  logic       btn_ones,
  input  logic       btn_tens,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [1:0] mode,
  output logic [2:0] state,
  output logic       heat_en,
  output logic       led,
  output logic       buzzer
);

  localparam logic [2:0] StOff   = 3'd0;
  localparam logic [2:0] StIdle  = 3'd1;
  localparam logic [2:0] StRun   = 3'd2;
  localparam logic [2:0] StPause = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;

  localparam int unsigned PrescW   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned BeepW    = (BEEP_ON + BEEP_OFF > 2) ? $clog2(BEEP_ON + BEEP_OFF) : 1;
  localparam int unsigned BeepNumW = (BEEP_COUNT > 1) ? $clog2(BEEP_COUNT + 1) : 1;

  logic [2:0]          state_q, state_d;
  logic [1:0]          mode_q, mode_d;
  logic [3:0]          min_tens_q, min_tens_d, min_ones_q, min_ones_d;
  logic [3:0]          sec_tens_q, sec_tens_d, sec_ones_q, sec_ones_d;
  logic                heat_en_q, heat_en_d, led_q, led_d, buzzer_q, buzzer_d;
  logic [PrescW-1:0]   presc_q, presc_d;
  logic [BeepW-1:0]    beep_cyc_q, beep_cyc_d;
  logic [BeepNumW-1:0] beep_num_q, beep_num_d;
  logic                presc_tick, min_set, any_btn;

`ifdef FRYER_PREHEAT_EN
  localparam logic [2:0]  StPreheat = 3'd5;
  localparam int unsigned PreW      = (PREHEAT_S > 1) ? $clog2(PREHEAT_S + 1) : 1;
  logic [PreW-1:0] pre_cnt_q, pre_cnt_d;
`else
  logic unused_preheat_s;
  assign unused_preheat_s = (PREHEAT_S != 0);
`endif

  function automatic logic [3:0] bcd_inc(input logic [3:0] d);
    return (d >= 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

  assign presc_tick = (presc_q == PrescW'(TICK_DIV - 1));
  assign min_set    = (min_tens_q != 4'd0) || (min_ones_q != 4'd0);
  assign any_btn    = btn_start | btn_reset | btn_pause | btn_mode | btn_ones | btn_tens;

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    min_tens_d = min_tens_q;
    min_ones_d = min_ones_q;
    sec_tens_d = sec_tens_q;
    sec_ones_d = sec_ones_q;
    presc_d    = presc_q;
    beep_cyc_d = beep_cyc_q;
    beep_num_d = beep_num_q;
`ifdef FRYER_PREHEAT_EN
    pre_cnt_d  = pre_cnt_q;
`endif
    if (!sw_power) begin
      state_d    = StOff;
      mode_d     = '0;
      min_tens_d = '0;
      min_ones_d = '0;
      sec_tens_d = '0;
      sec_ones_d = '0;
      presc_d    = '0;
      beep_cyc_d = '0;
      beep_num_d = '0;
    end else begin
      case (state_q)
        StOff: state_d = StIdle;
        StIdle: begin
          if (btn_reset) begin
            min_tens_d = '0;
            min_ones_d = '0;
          end else if (btn_start && min_set) begin
`ifdef FRYER_PREHEAT_EN
            state_d   = StPreheat;
            pre_cnt_d = '0;
`else
            state_d   = StRun;
`endif
            sec_tens_d = '0;
            sec_ones_d = '0;
            presc_d    = '0;
          end else begin
            if (btn_mode) mode_d = (mode_q >= 2'(MODE_NUM - 1)) ? 2'd0 : mode_q + 2'd1;
            if (btn_ones) min_ones_d = bcd_inc(min_ones_q);
            if (btn_tens) min_tens_d = bcd_inc(min_tens_q);
          end
        end
        StRun: begin
          if (btn_reset) begin
            state_d    = StIdle;
            min_tens_d = '0;
            min_ones_d = '0;
            sec_tens_d = '0;
            sec_ones_d = '0;
            presc_d    = '0;
          end else if (btn_pause) begin
            state_d = StPause;
          end else if (presc_tick) begin
            presc_d = '0;
            // BCD borrow chain; minutes only borrow when non-zero
            if (sec_ones_q != 4'd0) begin
              sec_ones_d = sec_ones_q - 4'd1;
            end else begin
              sec_ones_d = 4'd9;
              if (sec_tens_q != 4'd0) begin
                sec_tens_d = sec_tens_q - 4'd1;
              end else begin
                sec_tens_d = 4'd5;
                if (min_ones_q != 4'd0) begin
                  min_ones_d = min_ones_q - 4'd1;
                end else if (min_tens_q != 4'd0) begin
                  min_ones_d = 4'd9;
                  min_tens_d = min_tens_q - 4'd1;
                end
              end
            end
            if ({min_tens_d, min_ones_d, sec_tens_d, sec_ones_d} == 16'h0000) begin
              state_d    = StDone;
              beep_cyc_d = '0;
              beep_num_d = '0;
            end
          end else begin
            presc_d = presc_q + PrescW'(1);
          end
        end
        StPause: begin
          if (btn_reset) begin
            state_d    = StIdle;
            min_tens_d = '0;
            min_ones_d = '0;
            sec_tens_d = '0;
            sec_ones_d = '0;
            presc_d    = '0;
          end else if (btn_start || btn_pause) begin
            state_d = StRun;
          end
        end
        StDone: begin
          if (any_btn) begin
            state_d    = StIdle;
            beep_cyc_d = '0;
            beep_num_d = '0;
          end else if (beep_cyc_q == BeepW'(BEEP_ON + BEEP_OFF - 1)) begin
            beep_cyc_d = '0;
            if (beep_num_q == BeepNumW'(BEEP_COUNT - 1)) begin
              state_d    = StIdle;
              beep_num_d = '0;
            end else begin
              beep_num_d = beep_num_q + BeepNumW'(1);
            end
          end else begin
            beep_cyc_d = beep_cyc_q + BeepW'(1);
          end
        end
`ifdef FRYER_PREHEAT_EN
        StPreheat: begin
          if (btn_reset) begin
            state_d    = StIdle;
            min_tens_d = '0;
            min_ones_d = '0;
            sec_tens_d = '0;
            sec_ones_d = '0;
            presc_d    = '0;
          end else if (presc_tick) begin
            presc_d = '0;
            if (pre_cnt_q == PreW'(PREHEAT_S - 1)) begin
              state_d    = StRun;
              sec_tens_d = '0;
              sec_ones_d = '0;
            end else begin
              pre_cnt_d = pre_cnt_q + PreW'(1);
            end
          end else begin
            presc_d = presc_q + PrescW'(1);
          end
        end
`endif
        default: state_d = StOff;
      endcase
    end
  end

  always_comb begin
    heat_en_d = (state_d == StRun);
`ifdef FRYER_PREHEAT_EN
    if (state_d == StPreheat) heat_en_d = 1'b1;
`endif
    led_d    = heat_en_d || (state_d == StPause);
    buzzer_d = (state_d == StDone) && (32'(beep_cyc_d) < BEEP_ON);
  end

  always_ff @(posedge clk_1Khz or negedge rst) begin
    if (!rst) begin
      state_q    <= StOff;
      mode_q     <= '0;
      min_tens_q <= '0;
      min_ones_q <= '0;
      sec_tens_q <= '0;
      sec_ones_q <= '0;
      heat_en_q  <= 1'b0;
      led_q      <= 1'b0;
      buzzer_q   <= 1'b0;
      presc_q    <= '0;
      beep_cyc_q <= '0;
      beep_num_q <= '0;
`ifdef FRYER_PREHEAT_EN
      pre_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      min_tens_q <= min_tens_d;
      min_ones_q <= min_ones_d;
      sec_tens_q <= sec_tens_d;
      sec_ones_q <= sec_ones_d;
      heat_en_q  <= heat_en_d;
      led_q      <= led_d;
      buzzer_q   <= buzzer_d;
      presc_q    <= presc_d;
      beep_cyc_q <= beep_cyc_d;
      beep_num_q <= beep_num_d;
`ifdef FRYER_PREHEAT_EN
      pre_cnt_q  <= pre_cnt_d;
`endif
    end
  end

  assign state    = state_q;
  assign mode     = mode_q;
  assign min_tens = min_tens_q;
  assign min_ones = min_ones_q;
  assign sec_tens = sec_tens_q;
  assign sec_ones = sec_ones_q;
  assign heat_en  = heat_en_q;
  assign led      = led_q;
  assign buzzer   = buzzer_q;

endmodule

// File: tb/tb_fryer_cook_ctrl.sv
// Directed bench for fryer_cook_ctrl: vector table for IDLE settings plus countdown/beep sequences.
module tb_fryer_cook_ctrl;
  logic       clk_1Khz = 1'b0;
  logic       rst      = 1'b1;
  logic       sw_power = 1'b0;
  logic [5:0] btn      = '0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic [1:0] mode;
  logic [2:0] state;
  logic       heat_en, led, buzzer;

  always #5 clk_1Khz = ~clk_1Khz;

  fryer_cook_ctrl #(
    .MODE_NUM  (3),
    .TICK_DIV  (10),
    .BEEP_ON   (3),
    .BEEP_OFF  (2),
    .BEEP_COUNT(2),
    .PREHEAT_S (5)
  ) dut (
    .clk_1Khz (clk_1Khz),
    .rst      (rst),
    .sw_power (sw_power),
    .btn_start(btn[5]),
    .btn_reset(btn[4]),
    .btn_pause(btn[3]),
    .btn_mode (btn[2]),
    .btn_ones (btn[1]),
    .btn_tens (btn[0]),
    .min_tens (min_tens),
    .min_ones (min_ones),
    .sec_tens (sec_tens),
    .sec_ones (sec_ones),
    .mode     (mode),
    .state    (state),
    .heat_en  (heat_en),
    .led      (led),
    .buzzer   (buzzer)
  );

  localparam logic [5:0] BStart = 6'b100000;
  localparam logic [5:0] BReset = 6'b010000;
  localparam logic [5:0] BPause = 6'b001000;
  localparam logic [5:0] BMode  = 6'b000100;
  localparam logic [5:0] BOnes  = 6'b000010;
  localparam logic [5:0] BTens  = 6'b000001;

  int n_checks = 0;
  int n_errors = 0;

  logic [23:0] outv;
  assign outv = {state, mode, heat_en, led, buzzer, min_tens, min_ones, sec_tens, sec_ones};

  typedef struct {
    logic        sw;
    logic [5:0]  b;
    logic [23:0] exp;
  } vec_t;

  vec_t tbl [16];

  function automatic logic [23:0] ex(input logic [2:0] st, input logic [1:0] md, input logic he,
                                     input logic ld, input logic bz, input logic [15:0] t);
    return {st, md, he, ld, bz, t};
  endfunction

  task automatic chk(input string name, input logic [23:0] got, input logic [23:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%06h expected 0x%06h", name, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_1Khz);
    #1;
  endtask

  task automatic press(input logic [5:0] b);
    btn = b;
    cyc();
    btn = '0;
  endtask

  // Start a cook; with preheat the RUN phase begins 50 cycles later.
  task automatic start_cook();
    press(BStart);
`ifdef FRYER_PREHEAT_EN
    repeat (50) cyc();
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [9:0] pat;
    logic [3:0] e;
    pat = 10'b1110011100;

    tbl[0]  = '{1'b1, 6'b0,           ex(3'd1, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0000)};
    tbl[1]  = '{1'b1, BOnes,          ex(3'd1, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0100)};
    tbl[2]  = '{1'b1, BOnes,          ex(3'd1, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0200)};
    tbl[3]  = '{1'b1, BMode,          ex(3'd1, 2'd1, 1'b0, 1'b0, 1'b0, 16'h0200)};
    tbl[4]  = '{1'b1, BMode,          ex(3'd1, 2'd2, 1'b0, 1'b0, 1'b0, 16'h0200)};
    tbl[5]  = '{1'b1, BMode,          ex(3'd1, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0200)};
    tbl[6]  = '{1'b1, BMode,          ex(3'd1, 2'd1, 1'b0, 1'b0, 1'b0, 16'h0200)};
    tbl[7]  = '{1'b1, BOnes | BTens | BMode, ex(3'd1, 2'd2, 1'b0, 1'b0, 1'b0, 16'h1300)};
    tbl[8]  = '{1'b1, BReset | BOnes, ex(3'd1, 2'd2, 1'b0, 1'b0, 1'b0, 16'h0000)};
    tbl[9]  = '{1'b1, BStart,         ex(3'd1, 2'd2, 1'b0, 1'b0, 1'b0, 16'h0000)};
    tbl[10] = '{1'b1, BOnes,          ex(3'd1, 2'd2, 1'b0, 1'b0, 1'b0, 16'h0100)};
    tbl[11] = '{1'b0, BOnes,          ex(3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0000)};
    tbl[12] = '{1'b1, 6'b0,           ex(3'd1, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0000)};
    tbl[13] = '{1'b1, BMode,          ex(3'd1, 2'd1, 1'b0, 1'b0, 1'b0, 16'h0000)};
    tbl[14] = '{1'b1, BMode,          ex(3'd1, 2'd2, 1'b0, 1'b0, 1'b0, 16'h0000)};
    tbl[15] = '{1'b1, BMode,          ex(3'd1, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0000)};

    #2 rst = 1'b0;
    #1 chk("reset_async", outv, 24'h0);
    cyc();
    chk("reset_held", outv, 24'h0);
    rst = 1'b1;
    cyc();
    chk("off_no_power", outv, 24'h0);

    for (int i = 0; i < 16; i++) begin
      sw_power = tbl[i].sw;
      btn      = tbl[i].b;
      cyc();
      btn = '0;
      chk($sformatf("vec%0d", i), outv, tbl[i].exp);
    end

    // Digit wrap: tens cycles back to 0 without touching ones
    repeat (3) press(BOnes);
    for (int k = 0; k < 10; k++) begin
      press(BTens);
      e = 4'((k + 1) % 10);
      chk($sformatf("tens_wrap%0d", k), 24'({min_tens, min_ones}), 24'({e, 4'd3}));
    end
    repeat (7) press(BOnes);
    chk("ones_wrap", outv, ex(3'd1, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0000));

    // Countdown from 02:00, pause at 01:30 with prescaler at 4
    press(BMode);
    press(BOnes);
    press(BOnes);
    start_cook();
    chk("run_start", outv, ex(3'd2, 2'd1, 1'b1, 1'b1, 1'b0, 16'h0200));
    repeat (9) cyc();
    chk("run_pre_tick", outv, ex(3'd2, 2'd1, 1'b1, 1'b1, 1'b0, 16'h0200));
    cyc();
    chk("run_0159", outv, ex(3'd2, 2'd1, 1'b1, 1'b1, 1'b0, 16'h0159));
    repeat (294) cyc();
    chk("run_0130", outv, ex(3'd2, 2'd1, 1'b1, 1'b1, 1'b0, 16'h0130));
    press(BPause);
    chk("pause_enter", outv, ex(3'd3, 2'd1, 1'b0, 1'b1, 1'b0, 16'h0130));
    for (int i = 0; i < 50; i++) begin
      cyc();
      chk("pause_hold", outv, ex(3'd3, 2'd1, 1'b0, 1'b1, 1'b0, 16'h0130));
    end
    press(BStart);
    chk("resume", outv, ex(3'd2, 2'd1, 1'b1, 1'b1, 1'b0, 16'h0130));
    repeat (5) cyc();
    chk("resume_pre_tick", outv, ex(3'd2, 2'd1, 1'b1, 1'b1, 1'b0, 16'h0130));
    cyc();
    chk("resume_tick", outv, ex(3'd2, 2'd1, 1'b1, 1'b1, 1'b0, 16'h0129));
    repeat (889) cyc();
    chk("run_0001", outv, ex(3'd2, 2'd1, 1'b1, 1'b1, 1'b0, 16'h0001));
    cyc();
    chk("done_enter", outv, ex(3'd4, 2'd1, 1'b0, 1'b0, 1'b1, 16'h0000));
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("beep%0d", i), 24'({state, buzzer}), 24'({3'd4, pat[9-i]}));
      cyc();
    end
    chk("done_to_idle", outv, ex(3'd1, 2'd1, 1'b0, 1'b0, 1'b0, 16'h0000));

    // Button during beep silences at once
    press(BOnes);
    start_cook();
    repeat (600) cyc();
    chk("done2_enter", 24'({state, buzzer}), 24'({3'd4, 1'b1}));
    cyc();
    press(BMode);
    chk("beep_interrupt", 24'({state, buzzer}), 24'({3'd1, 1'b0}));

    // Reset beats start in the same RUN cycle
    press(BOnes);
    start_cook();
    repeat (3) cyc();
    press(BStart | BReset);
    chk("reset_over_start", outv, ex(3'd1, 2'd1, 1'b0, 1'b0, 1'b0, 16'h0000));

    // Power switch off mid-RUN
    press(BOnes);
    start_cook();
    repeat (3) cyc();
    sw_power = 1'b0;
    cyc();
    chk("power_off_run", outv, 24'h0);
    sw_power = 1'b1;
    cyc();
    chk("power_on_idle", outv, ex(3'd1, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0000));

    // Asynchronous reset in DONE
    press(BOnes);
    start_cook();
    repeat (600) cyc();
    chk("done3_enter", outv, ex(3'd4, 2'd0, 1'b0, 1'b0, 1'b1, 16'h0000));
    cyc();
    #2 rst = 1'b0;
    #1 chk("async_rst_done", outv, 24'h0);
    #2 rst = 1'b1;
    cyc();
    chk("after_rst_idle", outv, ex(3'd1, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0000));

`ifdef FRYER_PREHEAT_EN
    press(BOnes);
    press(BStart);
    for (int i = 0; i < 50; i++) begin
      chk("preheat", outv, ex(3'd5, 2'd0, 1'b1, 1'b1, 1'b0, 16'h0100));
      cyc();
    end
    chk("preheat_to_run", outv, ex(3'd2, 2'd0, 1'b1, 1'b1, 1'b0, 16'h0100));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
